// File: rtl/ef_sram_pkg.sv
// Shared types and helpers for the SRAM aspect-ratio adapter: mode decode,
// ConfigBits field positions, lane geometry and address shift.
package ef_sram_pkg;

    typedef enum logic [1:0] {
        MODE_X32 = 2'b00,
        MODE_X16 = 2'b01,
        MODE_X8  = 2'b10
    } mode_e;

    localparam int CFG_MODE_LO = 0;
    localparam int CFG_MODE_HI = 1;
    localparam int CFG_OREG    = 2;

    localparam int LANE_W   = 8;
    localparam int LANE_CNT = 4;

    // Mode and lane of an accepted read, frozen until its data returns.
    typedef struct packed {
        mode_e      mode;
        logic [1:0] lane;
    } rd_lane_t;

    // Encoding 11 is an alias for x32.
    function automatic mode_e decode_mode(input logic [1:0] cfg_mode);
        case (cfg_mode)
            2'b01:   return MODE_X16;
            2'b10:   return MODE_X8;
            default: return MODE_X32;
        endcase
    endfunction

    // Number of fabric address LSBs that select a lane instead of a word.
    function automatic int unsigned ad_shift(input mode_e mode);
        case (mode)
            MODE_X16: return 1;
            MODE_X8:  return 2;
            default:  return 0;
        endcase
    endfunction

endpackage

// File: rtl/ef_sram_lane_mux.sv
// Read-lane extraction: selects the captured lane of the macro word and
// zero-extends it to the full data width.
module ef_sram_lane_mux
    import ef_sram_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  mode_e             i_mode,
    input  logic [1:0]        i_lane,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_word
);

    always_comb begin
        // NOTE: default every output first so no branch can infer a latch.
        o_word = '0;
        case (i_mode)
            MODE_X16: o_word[2*LANE_W-1:0] = i_data[2*LANE_W*i_lane[0] +: 2*LANE_W];
            MODE_X8:  o_word[LANE_W-1:0]   = i_data[LANE_W*i_lane +: LANE_W];
            default:  o_word               = i_data;
        endcase
    end

endmodule

// File: rtl/ef_sram_aspect_adapter.sv
// Presents a 32-bit-wide SRAM macro to the fabric as x32, x16 or x8 memory,
// with an optional output register on the read path.
module ef_sram_aspect_adapter
    import ef_sram_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 10,
    parameter int NoConfigBits = 3
) (
    input  logic                    UserCLK,
    input  logic                    RST_N,
    input  logic [NoConfigBits-1:0] ConfigBits,
    input  logic [DATA_W-1:0]       DI,
    input  logic [DATA_W-1:0]       BEN,
    input  logic [ADDR_W+1:0]       AD,
    input  logic                    EN,
    input  logic                    R_WB,
    output logic [DATA_W-1:0]       DO,
    output logic                    DO_VALID,
    output logic [DATA_W-1:0]       DI_SRAM,
    output logic [DATA_W-1:0]       BEN_SRAM,
    output logic [ADDR_W-1:0]       AD_SRAM,
    output logic                    EN_SRAM,
    output logic                    R_WB_SRAM,
    input  logic [DATA_W-1:0]       DO_SRAM,
    output logic                    CLOCK_SRAM
);

    mode_e             w_mode;
    logic              w_oreg;
    logic [1:0]        w_lane;
    logic              w_rd_req;
    logic [DATA_W-1:0] w_extracted;

    logic              r_rd_pend;
    rd_lane_t          r_rd_lane;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] r_out;
    logic              r_valid;

    assign w_mode   = decode_mode(ConfigBits[CFG_MODE_HI:CFG_MODE_LO]);
    assign w_oreg   = ConfigBits[CFG_OREG];
    assign w_rd_req = EN & R_WB;

    always_comb begin
        w_lane = 2'b00;
        case (w_mode)
            MODE_X16: w_lane = {1'b0, AD[0]};
            MODE_X8:  w_lane = AD[1:0];
            default:  w_lane = 2'b00;
        endcase
    end

    // Lane-select bits drop off the bottom; surplus high AD bits never reach the macro.
    assign AD_SRAM = AD[ad_shift(w_mode) +: ADDR_W];

    always_comb begin
        DI_SRAM  = DI;
        BEN_SRAM = BEN;
        case (w_mode)
            MODE_X16: begin
                DI_SRAM  = {(LANE_CNT/2){DI[2*LANE_W-1:0]}};
                BEN_SRAM = '0;
                BEN_SRAM[2*LANE_W*w_lane[0] +: 2*LANE_W] = BEN[2*LANE_W-1:0];
            end
            MODE_X8: begin
                DI_SRAM  = {LANE_CNT{DI[LANE_W-1:0]}};
                BEN_SRAM = '0;
                BEN_SRAM[LANE_W*w_lane +: LANE_W] = BEN[LANE_W-1:0];
            end
            default: ;
        endcase
    end

    // Gating with RST_N keeps the macro idle while the fabric is still in reset.
    assign EN_SRAM    = EN & RST_N;
    assign R_WB_SRAM  = R_WB;
    assign CLOCK_SRAM = UserCLK;

    ef_sram_lane_mux #(
        .DATA_W (DATA_W)
    ) u_lane_mux (
        .i_mode (r_rd_lane.mode),
        .i_lane (r_rd_lane.lane),
        .i_data (DO_SRAM),
        .o_word (w_extracted)
    );

    always_ff @(posedge UserCLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rd_pend <= 1'b0;
            r_rd_lane <= '0;
            r_hold    <= '0;
            r_out     <= '0;
            r_valid   <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so each register samples pre-edge values.
            r_rd_pend <= w_rd_req;
            r_valid   <= r_rd_pend;
            if (w_rd_req) begin
                r_rd_lane <= '{mode: w_mode, lane: w_lane};
            end
            if (r_rd_pend) begin
                r_hold <= w_extracted;
                r_out  <= w_extracted;
            end
        end
    end

    // Both registers hold the same last result, so toggling the output
    // register between reads does not disturb the held DO value.
    assign DO       = w_oreg ? r_out : (r_rd_pend ? w_extracted : r_hold);
    assign DO_VALID = w_oreg ? r_valid : r_rd_pend;

endmodule

// File: tb/tb_ef_sram_aspect_adapter.sv
// Self-checking bench: combinational mapping table, directed corner cases and
// a randomized phase scored against a lane-arithmetic memory model.
module tb_ef_sram_aspect_adapter;

    localparam int ADDR_W = 10;
    localparam int AD_W   = ADDR_W + 2;

    logic            UserCLK;
    logic            RST_N;
    logic [2:0]      ConfigBits;
    logic [31:0]     DI, BEN, DO, DI_SRAM, BEN_SRAM, DO_SRAM;
    logic [AD_W-1:0] AD;
    logic [ADDR_W-1:0] AD_SRAM;
    logic            EN, R_WB, DO_VALID, EN_SRAM, R_WB_SRAM, CLOCK_SRAM;

    ef_sram_aspect_adapter #(
        .DATA_W       (32),
        .ADDR_W       (ADDR_W),
        .NoConfigBits (3)
    ) dut (
        .UserCLK    (UserCLK),
        .RST_N      (RST_N),
        .ConfigBits (ConfigBits),
        .DI         (DI),
        .BEN        (BEN),
        .AD         (AD),
        .EN         (EN),
        .R_WB       (R_WB),
        .DO         (DO),
        .DO_VALID   (DO_VALID),
        .DI_SRAM    (DI_SRAM),
        .BEN_SRAM   (BEN_SRAM),
        .AD_SRAM    (AD_SRAM),
        .EN_SRAM    (EN_SRAM),
        .R_WB_SRAM  (R_WB_SRAM),
        .DO_SRAM    (DO_SRAM),
        .CLOCK_SRAM (CLOCK_SRAM)
    );

    initial UserCLK = 1'b0;
    always #5 UserCLK = ~UserCLK;

    // Synchronous macro; output is garbage in the cycle after a write.
    logic [31:0] sram_mem [0:(1<<ADDR_W)-1];
    always @(posedge UserCLK) begin
        if (EN_SRAM) begin
            if (!R_WB_SRAM) begin
                sram_mem[AD_SRAM] <= (sram_mem[AD_SRAM] & ~BEN_SRAM) | (DI_SRAM & BEN_SRAM);
                DO_SRAM <= $urandom;
            end else begin
                DO_SRAM <= sram_mem[AD_SRAM];
            end
        end
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          due;
        logic [31:0] val;
    } exp_t;
    exp_t        sbq[$];
    logic [31:0] last_do;
    logic [31:0] ref_mem [0:(1<<ADDR_W)-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    function automatic int lane_bits(input logic [2:0] cfg);
        case (cfg[1:0])
            2'b01:   return 16;
            2'b10:   return 8;
            default: return 32;
        endcase
    endfunction

    // Reference model: memory as words, lanes addressed by plain arithmetic.
    task automatic ref_apply(input logic [2:0] cfg, input logic rwb, input logic [AD_W-1:0] ad,
                             input logic [31:0] di, input logic [31:0] ben,
                             output logic [31:0] rd, output logic [31:0] word);
        int     w     = lane_bits(cfg);
        int     lanes = 32 / w;
        int     widx  = (int'(ad) / lanes) % (1 << ADDR_W);
        int     sh    = (int'(ad) % lanes) * w;
        longint lm    = (64'd1 << w) - 1;
        logic [31:0] m, d;
        m = 32'((longint'(ben) & lm) << sh);
        d = 32'((longint'(di) & lm) << sh);
        if (!rwb) ref_mem[widx] = (ref_mem[widx] & ~m) | (d & m);
        rd   = 32'((longint'(ref_mem[widx]) >> sh) & lm);
        word = 32'(widx);
    endtask

    function automatic logic [AD_W-1:0] rand_ad(input logic [2:0] cfg);
        int lanes = 32 / lane_bits(cfg);
        int sh    = (lanes == 4) ? 2 : (lanes == 2) ? 1 : 0;
        logic [31:0] v;
        v = ($urandom_range(0, 7) << sh) | $urandom_range(0, lanes - 1) | (($urandom & 3) << (ADDR_W + sh));
        return v[AD_W-1:0];
    endfunction

    // Drive one request (called just after a falling edge) and score it in the model.
    task automatic do_op(input logic [2:0] cfg, input logic en, input logic rwb,
                         input logic [AD_W-1:0] ad, input logic [31:0] di, input logic [31:0] ben);
        logic [31:0] rd, word;
        ConfigBits = cfg; EN = en; R_WB = rwb; AD = ad; DI = di; BEN = ben;
        #1;
        check("en_sram", 32'(EN_SRAM), 32'(en));
        check("r_wb_sram", 32'(R_WB_SRAM), 32'(rwb));
        if (en) begin
            ref_apply(cfg, rwb, ad, di, ben, rd, word);
            check("ad_sram", 32'(AD_SRAM), word);
            if (rwb) sbq.push_back(exp_t'{cyc + 1 + int'(cfg[2]), rd});
        end
    endtask

    task automatic sb_check();
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            check("do_valid", 32'(DO_VALID), 32'd1);
            check("do_data", DO, sbq[0].val);
            last_do = sbq[0].val;
            void'(sbq.pop_front());
        end else begin
            check("do_valid_idle", 32'(DO_VALID), 32'd0);
            check("do_hold", DO, last_do);
        end
    endtask

    task automatic tick();
        @(posedge UserCLK);
        cyc++;
        @(negedge UserCLK);
        sb_check();
    endtask

    typedef struct {
        logic [1:0]        mode;
        logic              rwb;
        logic [AD_W-1:0]   ad;
        logic [31:0]       di;
        logic [31:0]       ben;
        logic [ADDR_W-1:0] exp_ad;
        logic [31:0]       exp_di;
        logic [31:0]       exp_ben;
    } map_vec_t;

    map_vec_t vecs[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{2'b00, 1'b0, 12'hC05, 32'hDEADBEEF, 32'hFFFF0000, 10'h005, 32'hDEADBEEF, 32'hFFFF0000};
        vecs[1] = '{2'b11, 1'b1, 12'h3FF, 32'h12345678, 32'h0F0F0F0F, 10'h3FF, 32'h12345678, 32'h0F0F0F0F};
        vecs[2] = '{2'b10, 1'b0, 12'h016, 32'h123456A5, 32'h000000FF, 10'h005, 32'hA5A5A5A5, 32'h00FF0000};
        vecs[3] = '{2'b10, 1'b1, 12'hFFF, 32'h0000003C, 32'h00000081, 10'h3FF, 32'h3C3C3C3C, 32'h81000000};
        vecs[4] = '{2'b01, 1'b0, 12'h003, 32'hBEEF1234, 32'hFFFF00F0, 10'h001, 32'h12341234, 32'h00F00000};
        vecs[5] = '{2'b01, 1'b1, 12'h800, 32'h0000CAFE, 32'h0000FFFF, 10'h000, 32'hCAFECAFE, 32'h0000FFFF};
        vecs[6] = '{2'b10, 1'b0, 12'h001, 32'hFFFFFF77, 32'hFFFFFFFF, 10'h000, 32'h77777777, 32'h0000FF00};

        last_do = '0;
        RST_N = 1'b0; ConfigBits = 3'b000; EN = 1'b1; R_WB = 1'b1;
        AD = '0; DI = '0; BEN = '0;
        #3;
        check("rst_do", DO, 32'd0);
        check("rst_do_valid", 32'(DO_VALID), 32'd0);
        check("rst_en_sram", 32'(EN_SRAM), 32'd0);
        EN = 1'b0;
        repeat (2) @(posedge UserCLK);
        @(negedge UserCLK);
        RST_N = 1'b1;

        for (int i = 0; i < 7; i++) begin
            ConfigBits = {1'b0, vecs[i].mode}; EN = 1'b0; R_WB = vecs[i].rwb;
            AD = vecs[i].ad; DI = vecs[i].di; BEN = vecs[i].ben;
            #1;
            check($sformatf("map%0d_ad", i), 32'(AD_SRAM), 32'(vecs[i].exp_ad));
            check($sformatf("map%0d_di", i), DI_SRAM, vecs[i].exp_di);
            check($sformatf("map%0d_ben", i), BEN_SRAM, vecs[i].exp_ben);
            check($sformatf("map%0d_rwb", i), 32'(R_WB_SRAM), 32'(vecs[i].rwb));
            check($sformatf("map%0d_en", i), 32'(EN_SRAM), 32'd0);
        end
        @(negedge UserCLK);

        for (int w = 0; w < 8; w++) begin
            do_op(3'b000, 1'b1, 1'b0, 12'(w), $urandom, 32'hFFFFFFFF);
            tick();
        end

        // x32, output register off: write then immediate read of the same word.
        do_op(3'b000, 1'b1, 1'b0, 12'd5, 32'hDEADBEEF, 32'hFFFFFFFF);
        tick();
        do_op(3'b000, 1'b1, 1'b1, 12'd5, 32'h0, 32'h0);
        tick();
        check("x32_do", DO, 32'hDEADBEEF);
        check("x32_valid", 32'(DO_VALID), 32'd1);
        do_op(3'b000, 1'b0, 1'b0, 12'd0, 32'h0, 32'h0);
        tick();

        // x8 byte write into lane 2 of word 5, then read it back.
        do_op(3'b010, 1'b1, 1'b0, 12'h016, 32'h000000A5, 32'h000000FF);
        check("x8_ad_sram", 32'(AD_SRAM), 32'd5);
        check("x8_ben_sram", BEN_SRAM, 32'h00FF0000);
        check("x8_di_sram", DI_SRAM, 32'hA5A5A5A5);
        tick();
        do_op(3'b010, 1'b1, 1'b1, 12'h016, 32'h0, 32'h0);
        tick();
        check("x8_do", DO, 32'h000000A5);

        // x8 read whose mode changes to x32 while its data is returning.
        do_op(3'b010, 1'b1, 1'b1, 12'h016, 32'h0, 32'h0);
        @(posedge UserCLK);
        cyc++;
        #1;
        ConfigBits = 3'b000; EN = 1'b0;
        @(negedge UserCLK);
        sb_check();
        check("mode_switch_do", DO, 32'h000000A5);
        do_op(3'b000, 1'b0, 1'b0, 12'd0, 32'h0, 32'h0);
        tick();

        // x16 with output register: back-to-back reads of both halves of word 1.
        do_op(3'b000, 1'b1, 1'b0, 12'd1, 32'h12345678, 32'hFFFFFFFF);
        tick();
        do_op(3'b100, 1'b0, 1'b0, 12'd0, 32'h0, 32'h0);
        tick();
        do_op(3'b101, 1'b1, 1'b1, 12'd3, 32'h0, 32'h0);
        tick();
        do_op(3'b101, 1'b1, 1'b1, 12'd2, 32'h0, 32'h0);
        tick();
        check("x16_oreg_first", DO, 32'h00001234);
        do_op(3'b101, 1'b0, 1'b0, 12'd0, 32'h0, 32'h0);
        tick();
        check("x16_oreg_second", DO, 32'h00005678);
        check("x16_oreg_valid", 32'(DO_VALID), 32'd1);
        tick();
        check("x16_oreg_hold", DO, 32'h00005678);

        // Reset lands with a read in flight: the read must vanish.
        do_op(3'b101, 1'b1, 1'b1, 12'd3, 32'h0, 32'h0);
        @(posedge UserCLK);
        cyc++;
        #1;
        RST_N = 1'b0;
        sbq.delete();
        last_do = '0;
        #1;
        check("rst_mid_en_sram", 32'(EN_SRAM), 32'd0);
        @(negedge UserCLK);
        sb_check();
        EN = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
        tick();
        tick();
        check("post_rst_do", DO, 32'd0);

        // First access right after deassertion.
        do_op(3'b101, 1'b1, 1'b1, 12'd2, 32'h0, 32'h0);
        tick();
        do_op(3'b101, 1'b0, 1'b0, 12'd0, 32'h0, 32'h0);
        tick();
        check("first_access_do", DO, 32'h00005678);
        repeat (2) tick();

        for (int p = 0; p < 2; p++) begin
            for (int n = 0; n < 250; n++) begin
                int r;
                logic [2:0] cfg;
                r   = $urandom_range(0, 9);
                cfg = {p[0], 2'($urandom_range(0, 3))};
                do_op(cfg, r < 7, r < 4, rand_ad(cfg), $urandom, $urandom);
                tick();
            end
            do_op({p[0], 2'b00}, 1'b0, 1'b0, 12'd0, 32'h0, 32'h0);
            repeat (3) tick();
        end

        if (sbq.size() != 0) begin
            check("sb_drained", 32'(sbq.size()), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
